// File: rtl/ccd_wb_master.sv
// Single-outstanding Wishbone classic master for the CCD register window.
// Optional bus timeout is enabled by defining CCD_WB_TIMEOUT_EN.
module ccd_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ADDR_BASE      = 32'h3000_0000
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_stb_q, wb_stb_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

`ifdef CCD_WB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  logic       rsp_err_q, rsp_err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       timeout;

  // The cycle that would bring the count up to the limit is the last BUS cycle.
  assign cnt_inc = cnt_q + 8'd1;
  assign timeout = (cnt_inc == TIMEOUT_LIM);
`else
  localparam logic [7:0] unused_timeout_lim = 8'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d     = state_q;
    wb_cyc_d    = wb_cyc_q;
    wb_stb_d    = wb_stb_q;
    wb_we_d     = wb_we_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef CCD_WB_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          state_d   = ST_BUS;
          wb_cyc_d  = 1'b1;
          wb_stb_d  = 1'b1;
          wb_we_d   = i_cmd_we;
          wb_addr_d = i_cmd_addr | ADDR_BASE;
          wb_data_d = i_cmd_data;
`ifdef CCD_WB_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end

      ST_BUS: begin
        if (i_wb_ack) begin
          state_d     = ST_RESP;
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = wb_we_q ? 32'd0 : i_wb_data;
`ifdef CCD_WB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (timeout) begin
          state_d     = ST_RESP;
          wb_cyc_d    = 1'b0;
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_err_d   = 1'b1;
          cnt_d       = cnt_inc;
        end else begin
          cnt_d       = cnt_inc;
`endif
        end
      end

      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        wb_cyc_d    = 1'b0;
        wb_stb_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Ready only once the FSM is settled in IDLE, so a response handshake never overlaps acceptance.
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= 32'd0;
      wb_data_q   <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef CCD_WB_TIMEOUT_EN
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rsp_err_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_rsp_err = rsp_err_q;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;
  assign o_wb_cyc    = wb_cyc_q;
  assign o_wb_stb    = wb_stb_q;
  assign o_wb_we     = wb_we_q;
  assign o_wb_addr   = wb_addr_q;
  assign o_wb_data   = wb_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

endmodule
